laplace_stream_ctrl: RTL

LAPLACE_STREAM_CTRL -- requirements
Module: laplace_stream_ctrl

---
 rtl/laplace_pkg.sv | 14 +
 rtl/laplace_stream_ctrl_if.sv | 30 +++
 rtl/laplace_line_buf.sv | 27 ++
 rtl/laplace_stream_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/laplace_pkg.sv
// Shared constants and state encoding for the Laplace stream controller.
package laplace_pkg;
   localparam int unsigned PIX_W     = 8;
   localparam int unsigned IMG_W_DEF = 512;
   localparam int unsigned IMG_H_DEF = 512;

   typedef logic [PIX_W-1:0] pix_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;
endpackage

// File: rtl/laplace_stream_ctrl_if.sv
// Stream, control and cross-window signals between the controller (slave) and its environment (master).
interface laplace_stream_ctrl_if;
   import laplace_pkg::*;

   logic start;
   logic busy;
   logic frame_done;
   logic in_valid;
   logic in_ready;
   pix_t in_pixel;
   pix_t b;
   pix_t d;
   pix_t e;
   pix_t f;
   pix_t h;
   pix_t lap_s;
   logic out_valid;
   logic out_ready;
   pix_t out_pixel;

   modport master (
      output start, in_valid, in_pixel, lap_s, out_ready,
      input  busy, frame_done, in_ready, b, d, e, f, h, out_valid, out_pixel
   );

   modport slave (
      input  start, in_valid, in_pixel, lap_s, out_ready,
      output busy, frame_done, in_ready, b, d, e, f, h, out_valid, out_pixel
   );
endinterface

// File: rtl/laplace_line_buf.sv
// One row of pixel storage; write and registered read happen together on each accepted pixel.
module laplace_line_buf
   import laplace_pkg::*;
#(
   parameter int unsigned  DEPTH = IMG_W_DEF,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [AW-1:0] wr_addr,
   input  logic [AW-1:0] rd_addr,
   input  pix_t          wr_data,
   output pix_t          rd_data
);
   pix_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) mem[wr_addr] <= wr_data;
   end

   // Read returns pre-write contents when rd_addr equals wr_addr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rd_data <= '0;
      else if (en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/laplace_stream_ctrl.sv
// Raster-stream controller that assembles a cross window for an external Laplace datapath
// and registers its result with a valid/ready output handshake.
module laplace_stream_ctrl
   import laplace_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF
) (
   input logic                  clk,
   input logic                  rst_n,
   laplace_stream_ctrl_if.slave bus
);
   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   state_t          state, state_nxt;
   logic [CW-1:0]   col, col_ahead;
   logic [RW-1:0]   row;
   logic            in_rdy, done, accept, last_col, last_pix, capture;
   pix_t            lb1_q, lb2_q, dd, ee, hh, opix;
   logic            oval;

   assign last_col  = (col == CW'(IMG_W - 1));
   assign last_pix  = last_col && (row == RW'(IMG_H - 1));
   assign col_ahead = last_col ? '0 : col + CW'(1);
   assign accept    = in_rdy && bus.in_valid;
   assign capture   = accept && (row >= RW'(2)) && (col >= CW'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (bus.start) state_nxt = RUN;
         RUN: begin
            in_rdy = !oval || bus.out_ready;
            if (in_rdy && bus.in_valid && last_pix) state_nxt = FLUSH;
         end
         FLUSH: if (!oval || bus.out_ready) begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (state == IDLE && bus.start) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= col_ahead;
         if (last_col) row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end
   end

   // lb1 holds the previous row and is read one column ahead so f is ready before its pixel arrives;
   // lb2 holds the row before that, refilled from lb1's output.
   laplace_line_buf #(.DEPTH(IMG_W)) u_lb1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .wr_addr (col),
      .rd_addr (col_ahead),
      .wr_data (bus.in_pixel),
      .rd_data (lb1_q)
   );

   laplace_line_buf #(.DEPTH(IMG_W)) u_lb2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .wr_addr (col),
      .rd_addr (col),
      .wr_data (lb1_q),
      .rd_data (lb2_q)
   );

   // Column shift of the previous-row taps plus the current-row west tap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dd <= '0;
         ee <= '0;
         hh <= '0;
      end else if (accept) begin
         hh <= bus.in_pixel;
         ee <= lb1_q;
         dd <= ee;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oval <= 1'b0;
         opix <= '0;
      end else if (capture) begin
         oval <= 1'b1;
         opix <= bus.lap_s;
      end else if (bus.out_ready) begin
         oval <= 1'b0;
      end
   end

   assign bus.busy       = (state != IDLE);
   assign bus.frame_done = done;
   assign bus.in_ready   = in_rdy;
   assign bus.b          = lb2_q;
   assign bus.d          = dd;
   assign bus.e          = ee;
   assign bus.f          = lb1_q;
   assign bus.h          = hh;
   assign bus.out_valid  = oval;
   assign bus.out_pixel  = opix;
endmodule
